lfsr_arbiter: RTL
=================

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter SEED_DEFAULT, default 4'b0001: LFSR value loaded on reset; a zero value SHALL be treated as 4'b0001.
REQ-002 Port clk, input, 1: the single clock; every register SHALL update on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 Port seed_valid, input, 1: request to load seed_data into the LFSR.
REQ-005 Port seed_data, input, 4: new LFSR seed value.
REQ-006 Port req, input, 2: req[i] high means requester i wants one random word.
REQ-007 Port gnt, output, 2: one-hot, one-cycle grant pulse.
REQ-008 Port rnd_data, output, 4: random word; valid only in a cycle where gnt is nonzero.
REQ-009 Port seed_err, output, 1: one-cycle pulse when a zero seed was substituted.
REQ-010 Port lfsr_o, output, 4: current LFSR state, for observation.

Function
REQ-011 LFSR SHALL be a 4-bit Fibonacci register with next = {q[2:0], q[3]^q[2]}, giving a period of 15.
REQ-012 From 4'b0001 the LFSR SHALL step 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001.
REQ-013 The FSM SHALL have three states: IDLE, GRANT and RESEED.
REQ-014 IDLE -> RESEED when seed_valid=1; seed_valid SHALL take priority over req.
REQ-015 IDLE -> GRANT when seed_valid=0 and req!=0; the winner SHALL be latched in the same edge.
REQ-016 In GRANT: gnt = one-hot winner and rnd_data = lfsr_o; on exit the LFSR SHALL advance one step; next state SHALL be IDLE.
REQ-017 In RESEED: the LFSR SHALL load seed_data, or 4'b0001 if seed_data==0; next state SHALL be IDLE.
REQ-018 A zero seed SHALL pulse seed_err for one cycle, in the cycle after the load edge.
REQ-019 gnt latency: req sampled high in IDLE at edge N SHALL give gnt high in cycle N to N+1; maximum throughput is one grant per 2 cycles.
REQ-020 Arbitration SHALL be round-robin using a 1-bit last-winner pointer: on a tie the requester that was not last granted wins; after reset the pointer favours requester 0.
REQ-021 A single requester SHALL be granted regardless of the pointer.
REQ-022 A req dropped while in GRANT SHALL NOT cancel the grant already issued.
REQ-023 The LFSR SHALL advance only on exit from GRANT, never while idle.
REQ-024 seed_valid arriving while in GRANT or RESEED SHALL be held off until the next IDLE; it is not lost if still asserted.
REQ-025 gnt SHALL be zero in IDLE and in RESEED.
REQ-026 rnd_data SHALL be 4'b0000 whenever gnt==0.

Reset
REQ-027 While reset=0 at an edge: state=IDLE, lfsr_o=SEED_DEFAULT (or 0001 if zero), gnt=0, rnd_data=0, seed_err=0, pointer=0.
REQ-028 Reset asserted mid-GRANT SHALL abort the grant; gnt SHALL be 0 in the cycle after that edge and the LFSR SHALL NOT advance.
REQ-029 Outputs SHALL hold their reset values, with no grants issued, for as long as reset=0.

Configuration
REQ-030 Macro LFSR_ARBITER_STATS_EN, when defined, SHALL add output gnt_cnt0 (8 bits) and output gnt_cnt1 (8 bits).
REQ-031 Each counter SHALL increment once per grant to its requester and saturate at 255; both counters SHALL clear on reset.
REQ-032 Without LFSR_ARBITER_STATS_EN the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset low for 2 cycles, then high with req=0 for 20 cycles -> lfsr_o stays 0001 and gnt stays 00 throughout.
REQ-034 req=01 held high -> gnt=01 every second cycle with rnd_data 0001, 0010, 0100, 1001, ...; wrap back to 0001 after 15 grants.
REQ-035 req=11 held high from reset -> gnt alternates 01, 10, 01, 10; rnd_data follows the REQ-012 sequence.
REQ-036 seed_valid=1 with seed_data=0000 -> lfsr_o=0001 and seed_err pulses once; seed_data=1011 -> lfsr_o=1011, next grant returns 1011, then 0111.
REQ-037 seed_valid and req=01 asserted in the same IDLE cycle -> RESEED first (gnt=00), then grant returns the new seed.
REQ-038 Reset pulsed low during a GRANT cycle -> gnt=00 on the next cycle, lfsr_o=0001; with STATS_EN, gnt_cnt0 reaches 255 after 300 grants and holds.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_arbiter
// Two-requester round-robin arbiter that hands out 4-bit pseudo-random words
// taken from a Fibonacci LFSR (next = {q[2:0], q[3]^q[2]}, period 15).
//
// Ports
//   clk        : single clock, every register updates on its rising edge
//   reset      : synchronous, active-low reset
//   seed_valid : request to load seed_data into the LFSR (wins over req)
//   seed_data  : new LFSR seed; zero is replaced by 4'b0001
//   req[1:0]   : req[i] high = requester i wants one random word
//   gnt[1:0]   : one-hot, one-cycle grant pulse
//   rnd_data   : random word, nonzero only while gnt is nonzero
//   seed_err   : one-cycle pulse after a zero seed was substituted
//   lfsr_o     : current LFSR state
//   gnt_cnt0/1 : saturating per-requester grant counters, present only when
//                the macro LFSR_ARBITER_STATS_EN is defined
//
// FSM: IDLE -> RESEED (seed_valid) or GRANT (any req); both return to IDLE.
// The LFSR only steps on the edge leaving GRANT, so an idle arbiter keeps
// its state and a reset during GRANT discards the pending step.
// -----------------------------------------------------------------------------
module lfsr_arbiter #(
    parameter logic [3:0] SEED_DEFAULT = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seed_valid,
    input  logic [3:0] seed_data,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [3:0] rnd_data,
    output logic       seed_err,
    output logic [3:0] lfsr_o
`ifdef LFSR_ARBITER_STATS_EN
    ,
    output logic [7:0] gnt_cnt0,
    output logic [7:0] gnt_cnt1
`endif
);

    // An all-zero LFSR would lock up, so a zero default is replaced.
    localparam logic [3:0] SEED_RESET = (SEED_DEFAULT == 4'b0000) ? 4'b0001 : SEED_DEFAULT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RESEED = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] lfsr_reg, lfsr_next;
    logic       winner_reg, winner_next;   // requester being granted
    logic       prio_reg, prio_next;       // requester favoured on a tie
    logic       seed_err_reg, seed_err_next;
    logic       pick;

    // Winner selection: a lone requester always wins; on a tie the
    // priority pointer decides. The pointer always points away from the
    // most recent winner, and resets to favour requester 0.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = prio_reg;
            default: pick = 1'b0;
        endcase
    end

    // FSM process 1: state and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            lfsr_reg     <= SEED_RESET;
            winner_reg   <= 1'b0;
            prio_reg     <= 1'b0;
            seed_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            winner_reg   <= winner_next;
            prio_reg     <= prio_next;
            seed_err_reg <= seed_err_next;
        end
    end

    // FSM process 2: next state and datapath next values
    always_comb begin
        state_next    = state_reg;
        lfsr_next     = lfsr_reg;
        winner_next   = winner_reg;
        prio_next     = prio_reg;
        seed_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (seed_valid) begin
                    state_next = RESEED;
                end else if (req != 2'b00) begin
                    state_next  = GRANT;
                    winner_next = pick;
                end
            end
            GRANT: begin
                state_next = IDLE;
                lfsr_next  = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
                prio_next  = ~winner_reg;
            end
            RESEED: begin
                state_next = IDLE;
                if (seed_data == 4'b0000) begin
                    lfsr_next     = 4'b0001;
                    seed_err_next = 1'b1;
                end else begin
                    lfsr_next = seed_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM process 3: outputs (decoded from registered state only)
    always_comb begin
        gnt      = 2'b00;
        rnd_data = 4'b0000;
        if (state_reg == GRANT) begin
            gnt      = winner_reg ? 2'b10 : 2'b01;
            rnd_data = lfsr_reg;
        end
    end

    assign seed_err = seed_err_reg;
    assign lfsr_o   = lfsr_reg;

`ifdef LFSR_ARBITER_STATS_EN
    logic [7:0] gnt_cnt_reg [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset) begin
                    gnt_cnt_reg[gi] <= 8'd0;
                end else if (gnt[gi] && (gnt_cnt_reg[gi] != 8'hFF)) begin
                    gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign gnt_cnt0 = gnt_cnt_reg[0];
    assign gnt_cnt1 = gnt_cnt_reg[1];
`endif

endmodule
